// File: rtl/pipo_arb_pkg.sv
// pipo_arbiter shared types: FSM state, hold counter width, one-hot helper.
// Optional feature macro used by the top: PIPO_ARB_LOCK_EN.
package pipo_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam int CNT_W = 4;

  function automatic logic [31:0] onehot(
    input int unsigned idx
  );
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/pipo_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible, scanning
// last+1, last+2, ... modulo N_REQ. Ports: eligible, last -> found, winner.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int OW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [OW-1:0]    last,
  output logic             found,
  output logic [OW-1:0]    winner
);

  // Scan from the farthest slot back to the nearest so the
  // nearest eligible index after last is the final assignment.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (eligible[(int'(last) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = OW'((int'(last) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter loading one shared WIDTH-bit PIPO register, then
// holding it HOLD_CYCLES cycles. Ports: clk, rst (async low), clr, req,
// data_in -> ack, q, owner, valid, busy. PIPO_ARB_LOCK_EN adds lock.
module pipo_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int OW          = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
`ifdef PIPO_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       q,
  output logic [OW-1:0]          owner,
  output logic                   valid,
  output logic                   busy
);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OW-1:0]    last_q, last_d;
  logic [WIDTH-1:0] q_d;
  logic [OW-1:0]    owner_d;
  logic             valid_d;
  logic [N_REQ-1:0] ack_d;
  logic [N_REQ-1:0] elig;
  logic             pick_found;
  logic [OW-1:0]    pick_w;
  logic             found;
  logic [OW-1:0]    win;

  // A requester acked this cycle still shows req high; mask it.
  assign elig = req & ~ack;

  rr_pick #(
    .N_REQ (N_REQ),
    .OW    (OW)
  ) u_pick (
    .eligible (elig),
    .last     (last_q),
    .found    (pick_found),
    .winner   (pick_w)
  );

`ifdef PIPO_ARB_LOCK_EN
  logic lock_hit;
  assign lock_hit = lock[owner] & elig[owner];
  assign found    = pick_found | lock_hit;
  assign win      = lock_hit ? owner : pick_w;
`else
  assign found = pick_found;
  assign win   = pick_w;
`endif

  assign busy = (state_q == ARB_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    q_d     = q;
    owner_d = owner;
    valid_d = valid;
    ack_d   = '0;
    if (clr) begin
      q_d     = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = ARB_IDLE;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (found) begin
            q_d     = data_in[int'(win)*WIDTH +: WIDTH];
            owner_d = win;
            valid_d = 1'b1;
            ack_d   = N_REQ'(onehot(32'(win)));
            last_d  = win;
            if (HOLD_CYCLES > 0) begin
              cnt_d   = CNT_W'(HOLD_CYCLES - 1);
              state_d = ARB_HOLD;
            end
          end
        end
        ARB_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ARB_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      last_q  <= OW'(N_REQ - 1);
      q       <= '0;
      owner   <= '0;
      valid   <= 1'b0;
      ack     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      q       <= q_d;
      owner   <= owner_d;
      valid   <= valid_d;
      ack     <= ack_d;
    end
  end

endmodule

// File: tb/tb_pipo_arbiter.sv
// Scoreboard bench for pipo_arbiter: a behavioural model pushes expected
// outputs per edge; a negedge monitor pops and compares.
module tb_pipo_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int OW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           clr = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [OW-1:0]  owner;
  logic           valid;
  logic           busy;
`ifdef PIPO_ARB_LOCK_EN
  logic [N-1:0]   lock = '0;
`endif

  always #5 clk = ~clk;

  pipo_arbiter #(
    .N_REQ       (N),
    .WIDTH       (W),
    .HOLD_CYCLES (H),
    .OW          (OW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .req     (req),
    .data_in (data_in),
`ifdef PIPO_ARB_LOCK_EN
    .lock    (lock),
`endif
    .ack     (ack),
    .q       (q),
    .owner   (owner),
    .valid   (valid),
    .busy    (busy)
  );

  typedef struct packed {
    logic [N-1:0]  ack;
    logic [W-1:0]  q;
    logic [OW-1:0] owner;
    logic          valid;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: "hold_left" = busy cycles still to come.
  logic [N-1:0] m_ack;
  logic [W-1:0] m_q;
  logic         m_valid;
  int           m_owner;
  int           m_last;
  int           m_hold;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic model_reset();
    m_ack   = '0;
    m_q     = '0;
    m_valid = 1'b0;
    m_owner = 0;
    m_last  = N - 1;
    m_hold  = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r,
                            input logic [N*W-1:0] d,
                            input logic c);
    logic [N-1:0] elig;
    int w;
    exp_t e;
    elig = r & ~m_ack;
    w = -1;
    if (c) begin
      m_q = '0; m_valid = 1'b0; m_ack = '0; m_hold = 0;
    end else if (m_hold > 0) begin
      m_hold--; m_ack = '0;
    end else begin
`ifdef PIPO_ARB_LOCK_EN
      if (lock[m_owner] && elig[m_owner]) w = m_owner;
`endif
      for (int k = 1; k <= N && w < 0; k++)
        if (elig[(m_last + k) % N]) w = (m_last + k) % N;
      if (w >= 0) begin
        m_q = d[w*W +: W];
        m_owner = w;
        m_valid = 1'b1;
        m_ack = N'(1 << w);
        m_last = w;
        m_hold = H;
      end else begin
        m_ack = '0;
      end
    end
    e.ack = m_ack;
    e.q = m_q;
    e.owner = OW'(m_owner);
    e.valid = m_valid;
    e.busy = (m_hold > 0);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] r,
                       input logic [N*W-1:0] d,
                       input logic c);
    req = r; data_in = d; clr = c;
    @(posedge clk);
    model_step(r, d, c);
    #1;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    req = '0;
    clr = 1'b0;
    #1;
    check("rst_async_q", int'(q), 0);
    check("rst_async_busy", int'(busy), 0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_hold_ack", int'(ack), 0);
    #1;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({ack, q, owner, valid, busy} !== e) begin
          errors++;
          $display("FAIL out cyc=%0d got ack=%b q=%h own=%0d v=%b b=%b exp ack=%b q=%h own=%0d v=%b b=%b",
                   cyc, ack, q, owner, valid, busy,
                   e.ack, e.q, e.owner, e.valid, e.busy);
        end
      end
      if (ack != '0) begin
        grant_log.push_back(int'(owner));
        grant_cyc.push_back(cyc);
      end
    end
  end

  initial begin : stim
    logic [N*W-1:0] words;
    logic [N-1:0]   r;
    words = {8'h13, 8'h12, 8'h11, 8'h10};
    model_reset();
    rst = 1'b0;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    check("reset_q", int'(q), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_ack", int'(ack), 0);
    check("reset_owner", int'(owner), 0);
    check("reset_busy", int'(busy), 0);
    #1;
    rst = 1'b1;

    repeat (13) cycle(4'b1111, words, 1'b0);
    @(negedge clk);
    #1;
    check("contention_count", (grant_log.size() >= 5) ? 1 : 0, 1);
    if (grant_log.size() >= 5) begin
      check("rr_order0", grant_log[0], 0);
      check("rr_order1", grant_log[1], 1);
      check("rr_order2", grant_log[2], 2);
      check("rr_order3", grant_log[3], 3);
      check("rr_order4", grant_log[4], 0);
      for (int i = 1; i < 5; i++)
        check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
    end

    repeat (3) cycle('0, words, 1'b0);
    cycle(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b0);
    repeat (3) cycle('0, words, 1'b0);

    cycle(4'b1111, words, 1'b0);
    cycle(4'b1101, words, 1'b0);
    repeat (6) cycle(4'b1101, words, 1'b0);

    repeat (3) cycle('0, words, 1'b0);
    cycle(4'b1111, words, 1'b1);
    cycle('0, words, 1'b0);

    repeat (3) cycle('0, words, 1'b0);
    cycle(4'b1111, words, 1'b0);
    mid_reset();
    repeat (3) cycle('0, words, 1'b0);

`ifdef PIPO_ARB_LOCK_EN
    cycle(4'b0010, words, 1'b0);
    repeat (3) cycle('0, words, 1'b0);
    lock = 4'b0010;
    cycle(4'b1010, words, 1'b0);
    repeat (2) cycle('0, words, 1'b0);
    lock = '0;
    cycle(4'b1010, words, 1'b0);
    repeat (3) cycle('0, words, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'b1111;
`ifdef PIPO_ARB_LOCK_EN
      lock = N'($urandom);
`endif
      cycle(r, N*W'($urandom), ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 149) == 0) mid_reset();
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipo_arbiter.md
# pipo_arbiter

Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between N_REQ requesters. Each requester presents a request and a data word. The arbiter grants one requester at a time, loads that word into the register and acknowledges it. The register is then held stable for HOLD_CYCLES cycles so the downstream consumer can read it before the next arbitration.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data and register width
- HOLD_CYCLES, 2, cycles the register is held after a load before re-arbitration (0..15)
- OW, $clog2(N_REQ), owner index width (derived)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- clr  in  1  synchronous clear of register contents
- req  in  N_REQ  per-requester request level
- data_in  in  N_REQ*WIDTH  requester i's word at bits [i*WIDTH +: WIDTH]
- ack  out  N_REQ  one-hot, one-cycle load acknowledge
- q  out  WIDTH  holding register contents
- owner  out  OW  index of the requester whose word is in q
- valid  out  1  q holds a word from a completed load
- busy  out  1  high while in HOLD

## Operation
- FSM states:
  - IDLE: arbitrate.
  - HOLD: count down, no arbitration.
- Reset (rst=0, immediate, also mid-HOLD): state=IDLE, q=0, valid=0, ack=0, owner=0, busy=0, hold counter=0, RR pointer last=N_REQ-1, so requester 0 has top priority first.
- Eligible set = req & ~ack. A requester acknowledged in the current cycle is masked for that cycle's arbitration.
- IDLE, eligible set non-empty: winner w = first eligible index scanning last+1, last+2, … modulo N_REQ. At the edge:
  - q ← data_in[w], owner ← w, valid ← 1, ack ← onehot(w), last ← w.
  - If HOLD_CYCLES>0: counter ← HOLD_CYCLES-1 and state ← HOLD. Otherwise stay in IDLE.
- IDLE, eligible set empty: ack ← 0; q, owner and valid are unchanged.
- HOLD: ack ← 0, counter decrements each cycle. At counter==0 the state returns to IDLE. Requests are not served during HOLD.
- clr=1: q ← 0, valid ← 0, ack ← 0, state ← IDLE, counter ← 0. owner and last are unchanged. clr has priority over a grant in the same cycle.
- Requester protocol:
  - Hold req and data_in stable until ack is seen.
  - Dropping req before ack withdraws the request; nothing is loaded.
  - req still high after ack is a new request, served in round-robin order.
- Data word width is exactly WIDTH. No transformation is applied to the loaded word.

## Timing
- Load latency: req sampled high at edge k in IDLE → q, owner, valid and ack are updated after edge k. ack is high exactly one cycle.
- busy is high for exactly HOLD_CYCLES cycles after the load edge.
- Throughput: one load per HOLD_CYCLES+1 cycles.
  - With HOLD_CYCLES=0, one load per cycle when different requesters alternate.
  - A single continuously-requesting requester is loaded every other cycle because of the ack mask.
- Fairness: with all requesters asserting, grants rotate 0,1,…,N_REQ-1,0. Any requester waits at most N_REQ-1 grants.
- All outputs are registered. There is no combinational path from req or data_in to any output.

## Configuration
- PIPO_ARB_LOCK_EN defined:
  - Adds input lock (N_REQ).
  - If lock[owner]=1 when the arbiter is in IDLE and req[owner]=1, owner wins regardless of RR order; the ack mask still applies.
  - lock bits of non-owners are ignored.
- Not defined: no lock port; pure round-robin.

## Structure
- Package pipo_arb_pkg holds:
  - state enum (ARB_IDLE, ARB_HOLD)
  - counter width constant (4 bits)
  - a function returning onehot(index)
- Sub-module rr_pick: combinational round-robin picker with inputs eligible[N_REQ] and last[OW], outputs found and winner[OW]. Instantiated once.

## Test plan
- Reset: hold rst=0 with req=4'b1111 → q=8'h00, valid=0, ack=0, owner=0, busy=0. Release rst → first load is requester 0's word and ack=4'b0001.
- Single request: req=4'b0100, data_in[2]=8'hA5, HOLD_CYCLES=2 → next cycle q=8'hA5, owner=2, ack=4'b0100, busy=1 for 2 cycles, then IDLE.
- Full contention: req=4'b1111, words 8'h10/11/12/13 → loads occur in order 0,1,2,3,0 at 3-cycle spacing.
- Withdrawal and clear:
  - Drop req[1] during HOLD → requester 1 is skipped at the next arbitration.
  - clr=1 in the same cycle as a pending grant → q=0, valid=0, no ack.
- Reset mid-HOLD: rst=0 with counter=1 → immediately IDLE, q=0. No ack is emitted after release unless requests are present.
- Lock (PIPO_ARB_LOCK_EN): owner=1, lock=4'b0010, req=4'b1010 → requester 1 is granted again ahead of requester 3. Clearing lock → requester 3 is next.
